// File: rtl/switch_debounce_if.sv
// Switch debounce signal bundle: raw levels in, debounced levels, edge pulses and change flag out.
// The slave modport is the debouncer; the master modport is whoever drives the raw switches.
interface switch_debounce_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] sw_raw;
    logic [WIDTH-1:0] sw_stable;
    logic [WIDTH-1:0] sw_rise;
    logic [WIDTH-1:0] sw_fall;
    logic             chg_flag;
    logic             chg_clr;

    modport master (
        output sw_raw,
        output chg_clr,
        input  sw_stable,
        input  sw_rise,
        input  sw_fall,
        input  chg_flag
    );

    modport slave (
        input  sw_raw,
        input  chg_clr,
        output sw_stable,
        output sw_rise,
        output sw_fall,
        output chg_flag
    );
endinterface

// File: rtl/switch_debounce.sv
// Per-bit switch debouncer: 2-flop synchronizer, then a change is accepted after DEBOUNCE_CYCLES stable cycles.
// Latency raw->stable is 1+DEBOUNCE_CYCLES edges after first capture; no backpressure, outputs all registered.
module switch_debounce #(
    parameter int WIDTH           = 8,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 16
) (
    input  logic           HCLK,
    input  logic           HRESETn,
    switch_debounce_if.slave sw
);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] s1_q, s1_d;
    logic [WIDTH-1:0] s2_q, s2_d;
    logic [WIDTH-1:0] stable_q, stable_d;
    logic [WIDTH-1:0] rise_q, rise_d;
    logic [WIDTH-1:0] fall_q, fall_d;
    logic [CNT_W-1:0] cnt_q [WIDTH];
    logic [CNT_W-1:0] cnt_d [WIDTH];
    logic             flag_q, flag_d;

    always_comb begin
        s1_d     = sw.sw_raw;
        s2_d     = s1_q;
        stable_d = stable_q;
        rise_d   = '0;
        fall_d   = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = '0;
            // Counter only runs while the synchronized level disagrees; any agreement restarts it.
            if (s2_q[i] != stable_q[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    stable_d[i] = s2_q[i];
                    rise_d[i]   = s2_q[i];
                    fall_d[i]   = ~s2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
        // Set wins over a simultaneous clear so a change is never lost.
        flag_d = (|(rise_d | fall_d)) | (flag_q & ~sw.chg_clr);
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            s1_q     <= '0;
            s2_q     <= '0;
            stable_q <= '0;
            rise_q   <= '0;
            fall_q   <= '0;
            flag_q   <= 1'b0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            s1_q     <= s1_d;
            s2_q     <= s2_d;
            stable_q <= stable_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            flag_q   <= flag_d;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign sw.sw_stable = stable_q;
    assign sw.sw_rise   = rise_q;
    assign sw.sw_fall   = fall_q;
    assign sw.chg_flag  = flag_q;
endmodule

// File: tb/tb_switch_debounce.sv
// Directed bench for switch_debounce with DEBOUNCE_CYCLES=4, WIDTH=8.
module tb_switch_debounce;
    logic HCLK;
    logic HRESETn;
    int   checks;
    int   errors;

    switch_debounce_if #(.WIDTH(8)) sif ();

    switch_debounce #(
        .WIDTH          (8),
        .DEBOUNCE_CYCLES(4),
        .CNT_W          (16)
    ) dut (
        .HCLK   (HCLK),
        .HRESETn(HRESETn),
        .sw     (sif.slave)
    );

    initial begin
        HCLK = 1'b0;
        forever #5 HCLK = ~HCLK;
    end

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [7:0] st, input logic [7:0] ri,
                           input logic [7:0] fa, input logic fl);
        chk({tag, "_stable"}, sif.sw_stable, st);
        chk({tag, "_rise"}, sif.sw_rise, ri);
        chk({tag, "_fall"}, sif.sw_fall, fa);
        chk({tag, "_flag"}, {7'b0, sif.chg_flag}, {7'b0, fl});
        chk({tag, "_excl"}, sif.sw_rise & sif.sw_fall, 8'h00);
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        HRESETn     = 1'b0;
        sif.sw_raw  = 8'h00;
        sif.chg_clr = 1'b0;
        #2;
        chk_all("reset", 8'h00, 8'h00, 8'h00, 1'b0);
        tick();
        tick();
        HRESETn = 1'b1;

        // Single bit held: accepted on the sixth edge after it is driven.
        sif.sw_raw = 8'h01;
        repeat (5) tick();
        chk_all("hold_pre", 8'h00, 8'h00, 8'h00, 1'b0);
        tick();
        chk_all("hold_acc", 8'h01, 8'h01, 8'h00, 1'b1);
        tick();
        chk_all("hold_post", 8'h01, 8'h00, 8'h00, 1'b1);
        sif.chg_clr = 1'b1;
        tick();
        sif.chg_clr = 1'b0;
        chk_all("clr1", 8'h01, 8'h00, 8'h00, 1'b0);

        // Three-cycle glitch on bit 3 must be rejected.
        sif.sw_raw = 8'h09;
        repeat (3) tick();
        sif.sw_raw = 8'h01;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk_all("glitch", 8'h01, 8'h00, 8'h00, 1'b0);
        end

        // Bounce on bit 2, then hold high.
        sif.sw_raw = 8'h05; tick();
        chk_all("bnc1", 8'h01, 8'h00, 8'h00, 1'b0);
        sif.sw_raw = 8'h01; tick();
        chk_all("bnc2", 8'h01, 8'h00, 8'h00, 1'b0);
        sif.sw_raw = 8'h05; tick();
        chk_all("bnc3", 8'h01, 8'h00, 8'h00, 1'b0);
        sif.sw_raw = 8'h01; tick();
        chk_all("bnc4", 8'h01, 8'h00, 8'h00, 1'b0);
        sif.sw_raw = 8'h05;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_all("bnc_wait", 8'h01, 8'h00, 8'h00, 1'b0);
        end
        tick();
        chk_all("bnc_acc", 8'h05, 8'h04, 8'h00, 1'b1);
        tick();
        chk_all("bnc_post", 8'h05, 8'h00, 8'h00, 1'b1);

        // Multi-bit rise to FF, then multi-bit fall to 0F with clear on the accept edge.
        sif.sw_raw = 8'hFF;
        repeat (5) tick();
        chk_all("ff_pre", 8'h05, 8'h00, 8'h00, 1'b1);
        tick();
        chk_all("ff_acc", 8'hFF, 8'hFA, 8'h00, 1'b1);
        sif.chg_clr = 1'b1;
        tick();
        sif.chg_clr = 1'b0;
        chk_all("clr2", 8'hFF, 8'h00, 8'h00, 1'b0);
        sif.sw_raw = 8'h0F;
        repeat (5) tick();
        chk_all("0f_pre", 8'hFF, 8'h00, 8'h00, 1'b0);
        sif.chg_clr = 1'b1;
        tick();
        chk_all("0f_acc", 8'h0F, 8'h00, 8'hF0, 1'b1);
        tick();
        sif.chg_clr = 1'b0;
        chk_all("0f_clr", 8'h0F, 8'h00, 8'h00, 1'b0);

        // Reset with counters at 3 discards progress.
        sif.sw_raw = 8'hAA;
        repeat (5) tick();
        chk_all("mid_pre", 8'h0F, 8'h00, 8'h00, 1'b0);
        HRESETn = 1'b0;
        #2;
        chk_all("mid_rst", 8'h00, 8'h00, 8'h00, 1'b0);
        tick();
        HRESETn = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_all("rel_wait", 8'h00, 8'h00, 8'h00, 1'b0);
        end
        tick();
        chk_all("rel_acc", 8'hAA, 8'hAA, 8'h00, 1'b1);
        tick();
        chk_all("rel_post", 8'hAA, 8'h00, 8'h00, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/switch_debounce.md
SWITCH_DEBOUNCE -- requirements
Module: switch_debounce

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, number of switch bits.
REQ-002 The block SHALL have parameter DEBOUNCE_CYCLES, default 50000, consecutive stable cycles required to accept a change.
REQ-003 The block SHALL have parameter CNT_W, default 16, counter width.
REQ-004 HCLK  input  1  system clock; all state updates on its rising edge.
REQ-005 HRESETn  input  1  asynchronous, active-low reset.
REQ-006 sw_raw  input  WIDTH  raw, asynchronous, bouncing board switch levels.
REQ-007 sw_stable  output  WIDTH  debounced switch levels; feeds the Switches input of the AHB switch peripheral.
REQ-008 sw_rise  output  WIDTH  one-cycle pulse per bit when sw_stable goes 0->1.
REQ-009 sw_fall  output  WIDTH  one-cycle pulse per bit when sw_stable goes 1->0.
REQ-010 chg_flag  output  1  sticky flag: set when any bit of sw_stable changes.
REQ-011 chg_clr  input  1  synchronous clear of chg_flag.

Function
REQ-012 Each bit SHALL pass through a 2-flop synchronizer (s1, s2); only s2 feeds the debounce logic.
REQ-013 Each bit SHALL own an independent CNT_W-bit counter; bits SHALL NOT interact.
REQ-014 If s2[i] == sw_stable[i], counter[i] SHALL load 0.
REQ-015 If s2[i] != sw_stable[i] and counter[i] < DEBOUNCE_CYCLES-1, counter[i] SHALL increment by 1.
REQ-016 If s2[i] != sw_stable[i] and counter[i] == DEBOUNCE_CYCLES-1, sw_stable[i] SHALL take s2[i] and counter[i] SHALL load 0.
REQ-017 The counter SHALL never exceed DEBOUNCE_CYCLES-1; no wrap-around.
REQ-018 Latency: sw_raw[i] changing before edge k and held SHALL change sw_stable[i] at edge k+1+DEBOUNCE_CYCLES.
REQ-019 Any return of s2[i] to sw_stable[i] before acceptance (glitch, bounce) SHALL clear counter[i]; sw_stable[i] SHALL not change.
REQ-020 sw_rise[i]/sw_fall[i] SHALL be registered and asserted for exactly one cycle, at the same edge that updates sw_stable[i].
REQ-021 sw_rise[i] and sw_fall[i] SHALL never both be high.
REQ-022 Multiple bits accepted on the same edge SHALL pulse simultaneously in their own positions.
REQ-023 chg_flag SHALL set on any edge where (sw_rise | sw_fall) becomes nonzero; it SHALL clear on chg_clr=1; simultaneous set and clear SHALL leave it set.
REQ-024 DEBOUNCE_CYCLES SHALL be >= 1 and <= 2^CNT_W; DEBOUNCE_CYCLES=1 gives acceptance one cycle after s2 differs.
REQ-025 All outputs SHALL be registered; no combinational path from sw_raw to any output.

Reset
REQ-026 On HRESETn low, asynchronously: s1, s2, sw_stable, sw_rise, sw_fall, all counters, chg_flag SHALL be 0.
REQ-027 Reset mid-count SHALL discard progress; after release with sw_raw[i]=1 held, sw_stable[i] SHALL rise at edge 2+DEBOUNCE_CYCLES after release, with a sw_rise[i] pulse and chg_flag set.

Verification (DEBOUNCE_CYCLES=4, WIDTH=8)
REQ-028 Hold sw_raw=8'h01 from edge 0 after reset -> sw_stable=8'h01 at edge 5, sw_rise=8'h01 for that cycle only, chg_flag=1.
REQ-029 From stable 8'h00, pulse sw_raw[3]=1 for 3 cycles, then 0 -> sw_stable stays 8'h00; no pulses; chg_flag stays 0.
REQ-030 Bounce bit 2 (1,0,1,0,1) then hold 1 -> sw_stable[2] rises exactly 5 edges after the last 0->1 raw transition; single sw_rise[2] pulse.
REQ-031 From sw_stable=8'hFF, set sw_raw=8'h0F -> sw_fall=8'hF0 on one cycle, sw_stable=8'h0F; chg_clr asserted on that same edge -> chg_flag remains 1; next chg_clr -> 0.
REQ-032 Assert HRESETn low with a counter at 3 -> all outputs 0 immediately; after release, sw_raw held 8'hAA -> sw_stable=8'hAA at edge 6 after release.
